// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path.
// Holds the fetch FSM encoding, the default reset PC and the instruction
// field positions used by the next-PC selection logic.
package mips_pkg;

    // Fetch sequencer state encoding (2-bit)
    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_EXEC  = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction field positions
    localparam int IMM_MSB  = 15;   // top bit of the I-type immediate
    localparam int JIDX_MSB = 25;   // top bit of the J-type target index

    // Sign-extended, word-scaled branch offset from the immediate field.
    function automatic logic [31:0] branch_offset(input logic [IMM_MSB:0] imm);
        return {{14{imm[IMM_MSB]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Purpose:      combinational next-PC selection (JR > J > taken branch > pc+4).
// Latency:      purely combinational, zero cycles.
// Backpressure: none; the caller decides when next_pc is consumed.
//
// Ports:
//   pc            current instruction address
//   inst_field    low 26 bits of the current instruction (jump index / imm)
//   rs_data       register target for JR/JALR
//   is_jr, is_jump, is_branch, branch_enable   decoded next-PC controls
//   pc_plus4      pc + 4 (also the link value)
//   next_pc       selected next fetch address
//   misalign      JR selected and target bits [1:0] were nonzero
module next_pc_mux
    import mips_pkg::*;
(
    input  logic [31:0]       pc,
    input  logic [JIDX_MSB:0] inst_field,
    input  logic [31:0]       rs_data,
    input  logic              is_jr,
    input  logic              is_jump,
    input  logic              is_branch,
    input  logic              branch_enable,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       next_pc,
    output logic              misalign
);

    always_comb begin
        pc_plus4 = pc + 32'd4;
        next_pc  = pc_plus4;
        misalign = 1'b0;
        if (is_jr) begin
            // Low bits are forced to zero; the flag reports what was dropped.
            next_pc  = {rs_data[31:2], 2'b00};
            misalign = |rs_data[1:0];
        end else if (is_jump) begin
            // Jump stays inside the 256 MB region of the delay-slot address.
            next_pc = {pc_plus4[31:28], inst_field, 2'b00};
        end else if (is_branch && branch_enable) begin
            next_pc = pc_plus4 + branch_offset(inst_field[IMM_MSB:0]);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Purpose:      PC register and fetch sequencer; holds the executing instruction.
// Latency:      1 cycle request + >=1 cycle execute with zero-wait memory.
// Backpressure: request held (valid, addr stable) until inst_req_ready; waits
//               indefinitely for inst_rdata_valid; advances only on exec_done.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   inst_req_valid/_ready    fetch request handshake, inst_addr == pc
//   inst_rdata/_valid        returned instruction word
//   pc, inst, inst_valid     currently executing instruction
//   exec_done + controls     retire current instruction, select next PC
//   pc_plus4                 link value for JAL/JALR
//   addr_misalign            one-cycle pulse after retiring a misaligned JR
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        inst_rdata_valid,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic        is_branch,
    input  logic        branch_enable,
    input  logic        is_jump,
    input  logic        is_jr,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic        addr_misalign
);

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic        jr_misalign;

    next_pc_mux u_next_pc_mux (
        .pc            (pc),
        .inst_field    (inst[JIDX_MSB:0]),
        .rs_data       (rs_data),
        .is_jr         (is_jr),
        .is_jump       (is_jump),
        .is_branch     (is_branch),
        .branch_enable (branch_enable),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc),
        .misalign      (jr_misalign)
    );

    assign inst_req_valid = (state == S_REQ);
    assign inst_addr      = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_RESET;
            pc            <= RESET_PC;
            inst          <= 32'h0;
            inst_valid    <= 1'b0;
            addr_misalign <= 1'b0;
        end else begin
            // Pulse only; re-armed below on the retiring edge.
            addr_misalign <= 1'b0;
            case (state)
                S_RESET: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (inst_req_ready) begin
                        // Zero-wait memory may return data with the accept.
                        if (inst_rdata_valid) begin
                            inst       <= inst_rdata;
                            inst_valid <= 1'b1;
                            state      <= S_EXEC;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (inst_rdata_valid) begin
                        inst       <= inst_rdata;
                        inst_valid <= 1'b1;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        pc            <= next_pc;
                        inst_valid    <= 1'b0;
                        addr_misalign <= jr_misalign;
                        state         <= S_REQ;
                    end
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and next-PC/fetch sequencer for the MIPS core, sitting directly downstream of `branch_control`. It consumes `branch_enable` together with the decoded jump/branch controls, selects the next PC, and fetches the next instruction from instruction memory over a valid/ready handshake. It holds the fetched instruction stable while the core executes it, and advances when the core signals completion.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_req_valid`  out  1  fetch request valid.
- `inst_req_ready`  in  1  memory accepts the request this cycle.
- `inst_addr`  out  32  fetch address; equals `pc`.
- `inst_rdata`  in  32  returned instruction word.
- `inst_rdata_valid`  in  1  `inst_rdata` valid this cycle.
- `pc`  out  32  PC of the instruction held in `inst`.
- `inst`  out  32  registered current instruction.
- `inst_valid`  out  1  `inst` is valid and executing.
- `exec_done`  in  1  core has finished the current instruction; next-PC controls are valid this cycle.
- `is_branch`  in  1  current instruction is a conditional branch.
- `branch_enable`  in  1  branch condition true (from `branch_control`).
- `is_jump`  in  1  J/JAL.
- `is_jr`  in  1  JR/JALR.
- `rs_data`  in  32  register target for JR/JALR.
- `pc_plus4`  out  32  `pc + 4`, for the JAL/JALR link write.
- `addr_misalign`  out  1  one-cycle pulse: the selected JR target had nonzero bits [1:0].

## Operation
- FSM states: `S_RESET`, `S_REQ`, `S_WAIT`, `S_EXEC`.
- `S_RESET`: entered on reset. Moves to `S_REQ` on the first clock edge after `rst` deasserts.
- `S_REQ`: `inst_req_valid`=1 and `inst_addr`=`pc`. Moves to `S_WAIT` when `inst_req_ready`=1. If `inst_rdata_valid` is also 1 in that same cycle, it captures the data and moves directly to `S_EXEC`.
- `S_WAIT`: `inst_req_valid`=0. On `inst_rdata_valid`=1, loads `inst`←`inst_rdata` and moves to `S_EXEC`.
- `S_EXEC`: `inst_valid`=1. On `exec_done`=1, loads `pc`←`next_pc` and moves to `S_REQ`. `inst_valid` drops the following cycle.
- Next-PC selection, highest priority first:
  - `is_jr` → `{rs_data[31:2],2'b00}`. `addr_misalign` pulses if `rs_data[1:0]`≠0.
  - `is_jump` → `{pc_plus4[31:28], inst[25:0], 2'b00}`.
  - `is_branch & branch_enable` → `pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}`.
  - Otherwise → `pc_plus4`.
- All additions are 32-bit modulo 2^32 (wrap, no overflow flag).
- Next-PC controls, `inst_rdata_valid`, and `inst_req_ready` are ignored outside the states where they apply. `exec_done` outside `S_EXEC` has no effect.
- Reset mid-operation: any in-flight fetch is abandoned. A late `inst_rdata_valid` arriving after reset while in `S_RESET`/`S_REQ` is ignored.

## Timing
- Reset values: `pc`=`RESET_PC`, `inst`=0, `inst_valid`=0, `inst_req_valid`=0, `addr_misalign`=0, state=`S_RESET`.
- `inst_addr`, `pc_plus4`, and `inst_req_valid` are combinational from registered state.
- Minimum per-instruction latency with zero-wait memory (ready and rdata in the same cycle), counted from `S_REQ` entry: 1 cycle `S_REQ`, then `S_EXEC` for ≥1 cycle. Two-cycle throughput.
- `addr_misalign` is registered: asserted for exactly the cycle after the `exec_done` edge.
- `inst` and `pc` are stable throughout `S_EXEC`.

## Structure
- Shared package `mips_pkg`: state encoding (2-bit), `RESET_PC` default, and the offset/field constants (`IMM_MSB`=15, `JIDX_MSB`=25).
- One natural sub-module: `next_pc_mux`, which is purely combinational and takes `pc`, `inst`, `rs_data`, and the control inputs to produce `next_pc` and the misalign flag. The FSM and registers stay in `pc_fetch_unit`.

## Test plan
- Reset, zero-wait memory, sequential flow → fetch addresses are 0x0, 0x4, 0x8; `inst_valid` is high one cycle after each fetch.
- Taken branch at pc=0x100, imm=0xFFFF → next fetch at 0x100. Not-taken branch with the same imm → next fetch at 0x104.
- Jump at pc=0xF000_0000, `inst[25:0]`=0x3FFFFFF → next fetch at 0xFFFF_FFFC. JR with `is_jump` also set and rs=0x2003 → next fetch at 0x2000, `addr_misalign` pulses once.
- Memory stalls: `inst_req_ready` low 3 cycles, then rdata 2 cycles later → `inst_req_valid` held with `inst_addr` constant; `inst` loads exactly on the rdata cycle.
- Wrap: pc=0xFFFF_FFFC, no branch → next fetch at 0x0000_0000. `pc_plus4` reads 0x0 during `S_EXEC`.
- `rst` asserted while in `S_WAIT`, stale `inst_rdata_valid` arrives 1 cycle after deassert → outputs return to reset values; stale data is ignored; a fresh fetch is issued at `RESET_PC`.
